// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store buffer in front of the single-port data memory.
// Stores are queued and drained in order whenever the port is idle. Loads take the
// port first, but a load that overlaps any queued store waits until that store drains.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 14,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    input  logic          drain_req,
    output logic          buf_empty,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    output logic          dm_sb_flag,
    output logic          dm_lb_flag,
    input  logic [DW-1:0] dm_dout
);
    localparam int          PW        = $clog2(DEPTH);
    localparam logic [AW:0] WORD_SPAN = (AW+1)'(3);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);

    // Handshake: a request transfers in a cycle where req_valid && req_ready;
    // req_ready never depends on anything the requester cannot see this cycle.

    // Store FIFO storage; entries carry {addr, data, byte}
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] byte_q;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;

    logic             full;
    logic             empty;
    logic             hazard;
    logic             load_acc;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] slot_valid;

    // Inclusive byte ranges, computed one bit wider so a word at the top of the
    // address space does not wrap back to zero.
    function automatic logic ranges_overlap(input logic [AW-1:0] s_addr, input logic s_byte,
                                            input logic [AW-1:0] l_addr, input logic l_byte);
        logic [AW:0] s_lo, s_hi, l_lo, l_hi;
        s_lo = {1'b0, s_addr};
        l_lo = {1'b0, l_addr};
        s_hi = s_lo + (s_byte ? '0 : WORD_SPAN);
        l_hi = l_lo + (l_byte ? '0 : WORD_SPAN);
        return (s_lo <= l_hi) && (l_lo <= s_hi);
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign buf_empty = empty;

    // Mark which physical slots currently hold a queued store
    always_comb begin
        logic [PW-1:0] off;
        slot_valid = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PW'(i) - rd_ptr_q;
            slot_valid[i] = ({1'b0, off} < count_q);
        end
    end

    // Detect a load that touches any byte still waiting in the FIFO
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && ranges_overlap(addr_q[i], byte_q[i], req_addr, req_byte)) begin
                hazard = 1'b1;
            end
        end
    end

    // Accept rules: full blocks loads too, so queued stores always get a chance to drain
    always_comb begin
        req_ready = rst_n && !full && !drain_req && (req_we || !hazard);
        load_acc  = req_valid && !req_we && req_ready;
        push      = req_valid && req_we && req_ready;
        pop       = rst_n && !empty && !load_acc;
    end

    // Next-state for FIFO pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Memory port arbitration: accepted load, else head-of-FIFO write, else idle
    always_comb begin
        dm_addr    = '0;
        dm_din     = '0;
        dm_we      = 1'b0;
        dm_sb_flag = 1'b0;
        dm_lb_flag = 1'b0;
        if (load_acc) begin
            dm_addr    = req_addr;
            dm_lb_flag = req_byte;
        end else if (pop) begin
            dm_addr    = addr_q[rd_ptr_q];
            dm_din     = data_q[rd_ptr_q];
            dm_sb_flag = byte_q[rd_ptr_q];
            dm_we      = 1'b1;
        end
    end

    // Control state and load response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= load_acc;
            if (load_acc) begin
                rsp_rdata_q <= dm_dout;
            end
        end
    end

    // FIFO payload write; contents need no reset since occupancy masks them
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= req_addr;
            data_q[wr_ptr_q] <= req_wdata;
            byte_q[wr_ptr_q] <= req_byte;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed scenarios plus random traffic against a queue/byte-array model.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int MEMSZ = 16388;
    localparam int EW    = AW + DW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_byte;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          drain_req, buf_empty;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din, dm_dout;
    logic          dm_we, dm_sb_flag, dm_lb_flag;

    int checks = 0;
    int errors = 0;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .drain_req(drain_req), .buf_empty(buf_empty),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_sb_flag(dm_sb_flag), .dm_lb_flag(dm_lb_flag), .dm_dout(dm_dout)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // ---------------- data memory model (little endian, lb sign-extended) ----------------
    logic [7:0] mem [MEMSZ];
    logic       mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else if (dm_we) begin
            mem[int'(dm_addr)] <= dm_din[7:0];
            if (!dm_sb_flag) begin
                mem[int'(dm_addr) + 1] <= dm_din[15:8];
                mem[int'(dm_addr) + 2] <= dm_din[23:16];
                mem[int'(dm_addr) + 3] <= dm_din[31:24];
            end
        end
    end

    always_comb begin
        int a;
        a = int'(dm_addr);
        if (dm_lb_flag) dm_dout = {{24{mem[a][7]}}, mem[a]};
        else            dm_dout = {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    end

    // ---------------- reference model + scoreboard ----------------
    // exp_q holds queued stores {addr, data, byte} in program order; gmem is the
    // memory image the model expects once those stores have been written.
    logic [EW-1:0] exp_q [$];
    logic [7:0]    gmem [MEMSZ];
    logic          gm_init  = 1'b0;
    logic          rsp_pend = 1'b0;
    logic [DW-1:0] rsp_exp  = '0;

    function automatic logic [DW-1:0] gread(input int a, input logic bt);
        if (bt) return {{24{gmem[a][7]}}, gmem[a]};
        return {gmem[a + 3], gmem[a + 2], gmem[a + 1], gmem[a]};
    endfunction

    function automatic logic overlaps(input int s, input logic sb, input int l, input logic lb);
        int s_hi, l_hi;
        s_hi = s + (sb ? 0 : 3);
        l_hi = l + (lb ? 0 : 3);
        return (s <= l_hi) && (l <= s_hi);
    endfunction

    always @(negedge clk) begin : scoreboard
        logic          hz, exp_ready, ld_acc, st_acc;
        logic [EW-1:0] e;
        int            ea;
        if (!gm_init) begin
            for (int i = 0; i < MEMSZ; i++) gmem[i] = init_byte(i);
            gm_init = 1'b1;
        end
        if (!rst_n) begin
            checks++;
            if (dm_we !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_reset_gating: got dm_we=%b req_ready=%b expected 0/0", dm_we, req_ready);
            end
            exp_q.delete();
            rsp_pend = 1'b0;
        end else begin
            checks++;
            if (buf_empty !== (exp_q.size() == 0)) begin
                errors++;
                $display("FAIL sb_buf_empty: got %b expected %b", buf_empty, exp_q.size() == 0);
            end
            checks++;
            if (rsp_valid !== rsp_pend) begin
                errors++;
                $display("FAIL sb_rsp_valid: got %b expected %b", rsp_valid, rsp_pend);
            end
            if (rsp_pend) begin
                checks++;
                if (rsp_rdata !== rsp_exp) begin
                    errors++;
                    $display("FAIL sb_rsp_rdata: got %h expected %h", rsp_rdata, rsp_exp);
                end
            end
            hz = 1'b0;
            foreach (exp_q[k]) begin
                if (overlaps(int'(exp_q[k][EW-1 -: AW]), exp_q[k][0], int'(req_addr), req_byte)) hz = 1'b1;
            end
            exp_ready = (exp_q.size() < DEPTH) && !drain_req && (req_we || !hz);
            if (req_valid) begin
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL sb_req_ready: got %b expected %b (addr %h we %b)", req_ready, exp_ready, req_addr, req_we);
                end
            end
            ld_acc = req_valid && !req_we && exp_ready;
            st_acc = req_valid && req_we && exp_ready;
            checks++;
            if (ld_acc) begin
                if (dm_we !== 1'b0 || dm_addr !== req_addr || dm_lb_flag !== req_byte ||
                    dm_sb_flag !== 1'b0 || dm_din !== '0) begin
                    errors++;
                    $display("FAIL sb_port_load: got we=%b addr=%h lb=%b sb=%b din=%h expected 0/%h/%b/0/0",
                             dm_we, dm_addr, dm_lb_flag, dm_sb_flag, dm_din, req_addr, req_byte);
                end
                rsp_exp = gread(int'(req_addr), req_byte);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (dm_we !== 1'b1 || dm_addr !== e[EW-1 -: AW] || dm_din !== e[DW:1] ||
                    dm_sb_flag !== e[0] || dm_lb_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_port_store: got we=%b addr=%h din=%h sb=%b expected 1/%h/%h/%b",
                             dm_we, dm_addr, dm_din, dm_sb_flag, e[EW-1 -: AW], e[DW:1], e[0]);
                end
                ea = int'(e[EW-1 -: AW]);
                gmem[ea] = e[8:1];
                if (!e[0]) begin
                    gmem[ea + 1] = e[16:9];
                    gmem[ea + 2] = e[24:17];
                    gmem[ea + 3] = e[32:25];
                end
            end else begin
                if (dm_we !== 1'b0 || dm_addr !== '0 || dm_din !== '0 || dm_sb_flag !== 1'b0 || dm_lb_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_port_idle: got we=%b addr=%h din=%h sb=%b lb=%b expected all 0",
                             dm_we, dm_addr, dm_din, dm_sb_flag, dm_lb_flag);
                end
            end
            rsp_pend = ld_acc;
            if (st_acc) exp_q.push_back({req_addr, req_wdata, req_byte});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic bt,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_byte  = bt;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 14'h010, 32'h1234_5678);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_buf_empty: got %b expected 1", buf_empty); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we: got %b expected 0", dm_we); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_store_order();
        logic [AW-1:0] addrs [3];
        addrs[0] = 14'h010;
        addrs[1] = 14'h020;
        addrs[2] = 14'h030;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b1, 1'b1, 1'b0, addrs[c], $urandom);
            else       idle();
            @(negedge clk);
            checks++;
            if (c >= 1 && c <= 3) begin
                if (dm_we !== 1'b1 || dm_addr !== addrs[c-1]) begin
                    errors++;
                    $display("FAIL order_drain_c%0d: got we=%b addr=%h expected 1/%h", c, dm_we, dm_addr, addrs[c-1]);
                end
            end else if (dm_we !== 1'b0) begin
                errors++;
                $display("FAIL order_idle_c%0d: got we=%b expected 0", c, dm_we);
            end
            if (c == 4) begin
                checks++;
                if (buf_empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", buf_empty); end
            end
            tick();
        end
    endtask

    task automatic test_load_hazard();
        int waited;
        drive(1'b1, 1'b1, 1'b0, 14'h100, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 1'b0, 14'h102, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || dm_we !== 1'b1 || dm_addr !== 14'h100) begin
            errors++;
            $display("FAIL hazard_stall: got ready=%b we=%b addr=%h expected 0/1/100", req_ready, dm_we, dm_addr);
        end
        tick();
        waited = -1;
        for (int n = 0; n < 10 && waited < 0; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) waited = n;
            tick();
        end
        idle();
        checks++;
        if (waited != 0) begin errors++; $display("FAIL hazard_accept: got wait %0d expected 0", waited); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata[15:0] !== 16'hDEAD) begin
            errors++;
            $display("FAIL hazard_rsp: got valid=%b data=%h expected 1/????dead", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_load_bypass();
        drive(1'b1, 1'b1, 1'b0, 14'h200, $urandom);
        tick();
        drive(1'b1, 1'b0, 1'b0, 14'h204, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 14'h204) begin
            errors++;
            $display("FAIL bypass_load: got ready=%b we=%b addr=%h expected 1/0/204", req_ready, dm_we, dm_addr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 14'h200) begin
            errors++;
            $display("FAIL bypass_after: got rsp_valid=%b we=%b addr=%h expected 1/1/200", rsp_valid, dm_we, dm_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (buf_empty !== 1'b1) begin errors++; $display("FAIL bypass_empty: got %b expected 1", buf_empty); end
        tick();
    endtask

    task automatic test_overlap_edges();
        drive(1'b1, 1'b1, 1'b0, 14'h400, $urandom);
        tick();
        drive(1'b1, 1'b0, 1'b1, 14'h404, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL edge_adjacent: got ready=%b expected 1", req_ready); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 14'h408, $urandom);
        tick();
        drive(1'b1, 1'b0, 1'b1, 14'h40B, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL edge_last_byte: got ready=%b expected 0", req_ready); end
        tick();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            tick();
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_byte_sign();
        drive(1'b1, 1'b1, 1'b1, 14'h300, 32'hABCD_EF80);
        tick();
        idle();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (buf_empty === 1'b1) break;
            tick();
        end
        tick();
        drive(1'b1, 1'b0, 1'b1, 14'h300, '0);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL byte_sign: got valid=%b data=%h expected 1/ffffff80", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_drain_req();
        drive(1'b1, 1'b1, 1'b0, 14'h600, $urandom);
        tick();
        drain_req = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 14'h604, $urandom);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || dm_we !== 1'b1) begin
            errors++;
            $display("FAIL drain_block: got ready=%b we=%b expected 0/1", req_ready, dm_we);
        end
        tick();
        @(negedge clk);
        checks++;
        if (buf_empty !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: got empty=%b ready=%b expected 1/0", buf_empty, req_ready);
        end
        tick();
        drain_req = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(14'h500 + 4 * i), $urandom);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 14'h3000, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dm_we !== 1'b0 || buf_empty !== 1'b0) begin
                errors++;
                $display("FAIL loadhold_c%0d: got we=%b empty=%b expected 0/0", i, dm_we, buf_empty);
            end
            tick();
        end
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (dm_we !== 1'b0) begin errors++; $display("FAIL midreset_we: got %b expected 0", dm_we); end
        tick();
        @(negedge clk);
        checks++;
        if (buf_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b expected 1", buf_empty); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dm_we !== 1'b0) begin errors++; $display("FAIL midreset_discard: got we=%b expected 0", dm_we); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 14'h50C, '0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drain_req = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'(14'h700 + $urandom_range(0, 15)), $urandom);
            tick();
        end
        drain_req = 1'b0;
        idle();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (buf_empty === 1'b1) break;
            tick();
        end
        checks++;
        if (buf_empty !== 1'b1) begin errors++; $display("FAIL random_final_empty: got %b expected 1", buf_empty); end
        tick();
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        rst_n     = 1'b0;
        drain_req = 1'b0;
        idle();
        test_reset();
        test_store_order();
        test_load_hazard();
        test_load_bypass();
        test_overlap_edges();
        test_byte_sign();
        test_drain_req();
        test_reset_mid_drain();
        test_random();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
